// File: rtl/ahb_lite_sram_slave.sv
// rtl/ahb_lite_sram_slave.sv - AHB-Lite SRAM leaf slave with wait states, byte lanes, ERROR response and RAW forwarding
module ahb_lite_sram_slave #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [1:0]            HTRANS,
    input  logic                  HMASTLOCK,
    input  logic                  HREADY,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [DATA_WIDTH-1:0] HRDATA
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int LB = $clog2(NB);
    localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int AW = LB + IW;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

    state_t                state_q, state_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic                  write_q, write_d;
    logic [2:0]            size_q, size_d;
    logic [3:0]            wcnt_q, wcnt_d;
    logic [DATA_WIDTH-1:0] hrdata_q, hrdata_d;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic                  accept, acc_err, misaligned;
    logic                  enter_data, rd_from_bus, rd_write, commit;
    logic [IW-1:0]         wr_idx, rd_idx;
    logic [DATA_WIDTH-1:0] wmask, wr_word, rd_word;

    wire unused_ok = &{1'b0, HBURST, HPROT, HMASTLOCK};

    assign accept = HSEL & HREADY & HTRANS[1];

    always_comb begin
        misaligned = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (i < int'(HSIZE) && HADDR[i]) misaligned = 1'b1;
        end
    end

    assign acc_err = (int'(HSIZE) > LB) | misaligned |
                     ((HADDR >> LB) >= ADDR_WIDTH'(MEM_DEPTH));

    // Lane mask for the committing write; only legal sizes ever reach DATA.
    always_comb begin
        wmask = '0;
        for (int i = 0; i < NB; i++) begin
            if (i >= int'(addr_q[LB-1:0]) && i < int'(addr_q[LB-1:0]) + (1 << size_q))
                wmask[8*i +: 8] = 8'hff;
        end
    end

    assign commit  = (state_q == S_DATA) && write_q;
    assign wr_idx  = addr_q[LB +: IW];
    assign wr_word = (mem[wr_idx] & ~wmask) | (HWDATA & wmask);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        write_d     = write_q;
        size_d      = size_q;
        wcnt_d      = wcnt_q;
        enter_data  = 1'b0;
        rd_from_bus = 1'b0;
        case (state_q)
            S_WAIT: begin
                if (wcnt_q == 4'd0) begin
                    state_d    = S_DATA;
                    enter_data = 1'b1;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            S_ERR1: state_d = S_ERR2;
            default: begin
                state_d = S_IDLE;
                if (accept) begin
                    addr_d  = HADDR[AW-1:0];
                    write_d = HWRITE;
                    size_d  = HSIZE;
                    if (acc_err) begin
                        state_d = S_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        wcnt_d  = 4'(WAIT_STATES - 1);
                    end else begin
                        state_d     = S_DATA;
                        enter_data  = 1'b1;
                        rd_from_bus = 1'b1;
                    end
                end
            end
        endcase
    end

    // A zero-wait read entering DATA may target the word being written this edge.
    assign rd_idx   = rd_from_bus ? HADDR[LB +: IW] : addr_q[LB +: IW];
    assign rd_write = rd_from_bus ? HWRITE : write_q;
    assign rd_word  = (commit && wr_idx == rd_idx) ? wr_word : mem[rd_idx];
    assign hrdata_d = (enter_data && !rd_write) ? rd_word : '0;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            write_q  <= 1'b0;
            size_q   <= 3'd0;
            wcnt_q   <= 4'd0;
            hrdata_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            write_q  <= write_d;
            size_q   <= size_d;
            wcnt_q   <= wcnt_d;
            hrdata_q <= hrdata_d;
        end
    end

    always_ff @(posedge HCLK) begin
        if (commit) mem[wr_idx] <= wr_word;
    end

    assign HREADYOUT = !(state_q == S_WAIT || state_q == S_ERR1);
    assign HRESP     = (state_q == S_ERR1) || (state_q == S_ERR2);
    assign HRDATA    = hrdata_q;
endmodule
